iir_sample_server: RTL
======================

// Module: iir_sample_server
// PURPOSE
//   Memory-side responder for the IIR filter's sample/result interface.
//   Stores a host-loaded input record and serves DIn for each RAddr the filter presents while load=1.
//   Captures Yn at WAddr on WEN and raises data_done at the last sample.
//   Reports completion, a running checksum and sticky protocol errors to the host/test controller.
// PARAMETERS
//   N        16   sample / result width (signed)
//   M        20   filter address width (RAddr, WAddr)
//   AW       10   internal buffer address width; capacity 2**AW samples each for input and result
//   TIMEOUT  64   cycles allowed after data_done before RUN aborts without Finish
// PORTS
//   clk           in   1    clock, rising-edge; filter side runs on falling edge of same clk
//   rst           in   1    synchronous, active-high reset
//   host_wr_en    in   1    write host_wr_data into input buffer (ignored unless IDLE)
//   host_wr_addr  in   AW   input buffer write address
//   host_wr_data  in   N    input sample
//   host_len      in   AW+1 record length L, sampled on start
//   start         in   1    begin a run (ignored unless IDLE)
//   host_rd_addr  in   AW   result buffer read address
//   host_rd_data  out  N    result buffer data, registered, 1-cycle latency
//   busy          out  1    high in RUN
//   done          out  1    one-cycle pulse on entering DONE
//   checksum      out  N+AW sum of captured Yn (sign-extended), cleared on start
//   wr_count      out  AW+1 number of captured results this run
//   err_rd_oob    out  1    sticky: load with RAddr >= L
//   err_wr_oob    out  1    sticky: WEN with WAddr >= L
//   err_timeout   out  1    sticky: Finish not seen within TIMEOUT cycles after data_done
//   load          in   1    filter read request
//   RAddr         in   M    filter read address
//   DIn           out  N    sample to filter, registered
//   data_done     out  1    last sample has been served
//   WEN           in   1    filter write strobe
//   Yn            in   N    filter result
//   WAddr         in   M    filter write address
//   Finish        in   1    filter completion
// BEHAVIOUR
//   Reset: state=IDLE; DIn, data_done, busy, done, host_rd_data, checksum, wr_count, all err_* = 0; L=0.
//     Buffer contents are not reset.
//   FSM IDLE -> RUN on start && host_len!=0; IDLE -> DONE on start && host_len==0.
//     RUN -> DONE on Finish==1 or on timeout.
//     DONE -> IDLE after one cycle. busy==(state==RUN); done==(state==DONE).
//   On start (either path): L<=host_len; checksum, wr_count, err_* <= 0; data_done<=0; tcnt<=0.
//   host_len > 2**AW is clamped to 2**AW.
//   IDLE: host_wr_en writes in_buf[host_wr_addr]. In RUN/DONE, host writes are dropped.
//   host_rd_data <= out_buf[host_rd_addr] every cycle, any state.
//   RUN, rising edge with load=1:
//     - RAddr<L: DIn <= in_buf[RAddr[AW-1:0]].
//     - RAddr>=L: DIn <= 0 and err_rd_oob <= 1.
//     - DIn is valid for the filter's following falling edge.
//   RUN: data_done <= 1 on the edge where load=1 and RAddr==L-1; it stays 1 until the next start or reset.
//   RUN, WEN=1 on the same rising edge:
//     - WAddr<L: out_buf[WAddr] <= Yn, wr_count+=1, checksum += sext(Yn) (wraps modulo 2**(N+AW)).
//     - WAddr>=L: write dropped, err_wr_oob <= 1, checksum unchanged.
//   load and WEN on the same edge are independent; both are serviced.
//   Timeout: tcnt counts RUN cycles with data_done=1.
//     At tcnt==TIMEOUT-1 without Finish: err_timeout<=1 and go to DONE.
//     If Finish and timeout coincide, Finish wins: no error.
//   load/WEN outside RUN: no effect on DIn or buffers. DIn holds its last value.
//   rst mid-RUN: return to IDLE with reset values next edge. Buffers are not cleared.
// TESTING
//   1. Load L=4 samples {100,-200,300,-400}; filter model reads 0..3.
//      -> DIn sequence 100,-200,300,-400; data_done=1 after the RAddr=3 edge.
//   2. Filter writes Yn {5,-3,7,1} at WAddr 0..3, then Finish.
//      -> checksum=10, wr_count=4, done pulse 1 cycle, host_rd_addr=1 returns -3 next cycle.
//   3. L=2, filter presents RAddr=2 with load and WEN at WAddr=5.
//      -> DIn=0, err_rd_oob=1, err_wr_oob=1, wr_count unchanged.
//   4. L=3, filter never asserts Finish.
//      -> err_timeout=1 and done exactly TIMEOUT cycles after data_done rises.
//   5. start with host_len=0 -> done the next cycle, busy never 1. start during RUN -> ignored.
//   6. rst asserted mid-RUN at sample 2 -> all outputs 0 next edge.
//      A new start with L=4 replays case 1 correctly.

Source files
------------

// File: rtl/iir_sample_server_if.sv
// Filter-side sample/result interface between the IIR filter (master) and its memory-side server (slave).
interface iir_sample_server_if #(
  parameter int unsigned N = 16,
  parameter int unsigned M = 20
) ();
  logic         load;
  logic [M-1:0] RAddr;
  logic [N-1:0] DIn;
  logic         data_done;
  logic         WEN;
  logic [N-1:0] Yn;
  logic [M-1:0] WAddr;
  logic         Finish;

  modport master (output load, RAddr, WEN, Yn, WAddr, Finish, input DIn, data_done);
  modport slave  (input load, RAddr, WEN, Yn, WAddr, Finish, output DIn, data_done);
endinterface

// File: rtl/iir_sample_server.sv
// Memory-side responder for the IIR filter: serves a host-loaded input record, captures results,
// and reports completion, checksum and sticky protocol errors.
module iir_sample_server #(
  parameter int unsigned N       = 16,
  parameter int unsigned M       = 20,
  parameter int unsigned AW      = 10,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                host_wr_en,
  input  logic [AW-1:0]       host_wr_addr,
  input  logic [N-1:0]        host_wr_data,
  input  logic [AW:0]         host_len,
  input  logic                start,
  input  logic [AW-1:0]       host_rd_addr,
  output logic [N-1:0]        host_rd_data,
  output logic                busy,
  output logic                done,
  output logic [N+AW-1:0]     checksum,
  output logic [AW:0]         wr_count,
  output logic                err_rd_oob,
  output logic                err_wr_oob,
  output logic                err_timeout,
  iir_sample_server_if.slave  flt
);
  localparam int unsigned DEPTH = 1 << AW;
  localparam int unsigned LW    = AW + 1;
  localparam int unsigned CW    = N + AW;
  localparam int unsigned TW    = $clog2(TIMEOUT) + 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t          state, state_d;
  logic [LW-1:0]   len_q, len_clamped;
  logic [TW-1:0]   tcnt;
  logic [N-1:0]    din_q;
  logic            data_done_q;
  logic [N-1:0]    in_buf  [DEPTH];
  logic [N-1:0]    out_buf [DEPTH];
  logic            start_ok, rd_hit, wr_hit, rd_ok, wr_ok, last_rd, timeout_hit;

  assign flt.DIn       = din_q;
  assign flt.data_done = data_done_q;

  // Request decode shared by FSM and datapath
  always_comb begin
    len_clamped = (host_len > LW'(DEPTH)) ? LW'(DEPTH) : host_len;
    start_ok    = start && (state == S_IDLE);
    rd_hit      = (state == S_RUN) && flt.load;
    wr_hit      = (state == S_RUN) && flt.WEN;
    rd_ok       = flt.RAddr < M'(len_q);
    wr_ok       = flt.WAddr < M'(len_q);
    last_rd     = flt.RAddr == (M'(len_q) - M'(1));
    timeout_hit = (state == S_RUN) && data_done_q && (tcnt == TW'(TIMEOUT - 1)) && !flt.Finish;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      S_IDLE: if (start) state_d = (host_len == '0) ? S_DONE : S_RUN;
      S_RUN:  if (flt.Finish || timeout_hit) state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Status, sample path and result accounting
  always_ff @(posedge clk) begin
    if (rst) begin
      busy         <= 1'b0;
      done         <= 1'b0;
      len_q        <= '0;
      tcnt         <= '0;
      din_q        <= '0;
      data_done_q  <= 1'b0;
      checksum     <= '0;
      wr_count     <= '0;
      err_rd_oob   <= 1'b0;
      err_wr_oob   <= 1'b0;
      err_timeout  <= 1'b0;
      host_rd_data <= '0;
    end else begin
      busy         <= (state_d == S_RUN);
      done         <= (state_d == S_DONE);
      host_rd_data <= out_buf[host_rd_addr];
      if (start_ok) begin
        len_q       <= len_clamped;
        tcnt        <= '0;
        data_done_q <= 1'b0;
        checksum    <= '0;
        wr_count    <= '0;
        err_rd_oob  <= 1'b0;
        err_wr_oob  <= 1'b0;
        err_timeout <= 1'b0;
      end else if (state == S_RUN) begin
        if (data_done_q) tcnt <= tcnt + TW'(1);
        if (timeout_hit) err_timeout <= 1'b1;
        if (rd_hit) begin
          if (rd_ok) din_q <= in_buf[flt.RAddr[AW-1:0]];
          else begin
            din_q      <= '0;
            err_rd_oob <= 1'b1;
          end
          if (last_rd) data_done_q <= 1'b1;
        end
        if (wr_hit) begin
          if (wr_ok) begin
            wr_count <= wr_count + LW'(1);
            checksum <= checksum + CW'({{AW{flt.Yn[N-1]}}, flt.Yn});
          end else begin
            err_wr_oob <= 1'b1;
          end
        end
      end
    end
  end

  // Sample and result storage; contents survive reset
  always_ff @(posedge clk) begin
    if (!rst && (state == S_IDLE) && host_wr_en) in_buf[host_wr_addr] <= host_wr_data;
    if (!rst && wr_hit && wr_ok) out_buf[flt.WAddr[AW-1:0]] <= flt.Yn;
  end
endmodule
